uart_fifo_param: RTL

UART_FIFO_PARAM -- requirements
Module: uart_fifo_param

---
 rtl/uart_fifo_param.sv | 393 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_param.sv
// uart_fifo_param: memory-mapped UART with TX and RX FIFOs, 16x oversampling.
// Registers: TXD at BASE_ADDR, RXD at BASE_ADDR+4, STAT at BASE_ADDR+8.
// Optional feature: define UART_PARITY_EN to add an even parity bit to every frame.
module uart_fifo_param #(
    parameter logic [31:0] BASE_ADDR  = 32'h40000018,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_DIV    = 326,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Add,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RXD,
    output logic        UART_TXD,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [31:0] TXD_ADDR  = BASE_ADDR;
    localparam logic [31:0] RXD_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd8;
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} uart_state_e;

`ifdef UART_PARITY_EN
    localparam uart_state_e AfterData = StPar;
`else
    localparam uart_state_e AfterData = StStop;
`endif

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DW'(CLK_DIV - 1));

    // Free-running divider producing one tick every CLK_DIV cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_txd, wr_stat, rd_rxd;

    assign wr_txd  = wr && (Add == TXD_ADDR);
    assign wr_stat = wr && (Add == STAT_ADDR);
    assign rd_rxd  = rd && (Add == RXD_ADDR);

    // Only selected bits of wdata carry meaning; fold the rest away.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp_q, tx_rp_q;
    logic        tx_empty, tx_full, tx_push, tx_pop, tx_ovf;
    logic [7:0]  tx_wdata, tx_head;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
    // A write into a full FIFO still lands if the transmitter pops the same cycle.
    assign tx_push  = wr_txd && (!tx_full || tx_pop);
    assign tx_ovf   = wr_txd && tx_full && !tx_pop;

    // Zero-extend the character to the 8-bit storage width
    always_comb begin
        tx_wdata = '0;
        tx_wdata[DATA_BITS-1:0] = wdata[DATA_BITS-1:0];
    end

    // TX storage write port
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp_q[AW-1:0]] <= tx_wdata;
        end
    end

    // TX pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp_q, rx_rp_q;
    logic        rx_empty, rx_full, rx_push, rx_pop, rx_ovf, rx_done;
    logic [7:0]  rx_head;

    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];
    assign rx_pop   = rd_rxd && !rx_empty;
    assign rx_push  = rx_done && (!rx_full || rx_pop);
    assign rx_ovf   = rx_done && rx_full && !rx_pop;

    // RX storage write port
    logic [7:0] rx_data_q, rx_data_d;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wp_q[AW-1:0]] <= rx_data_q;
        end
    end

    // RX pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX line synchroniser and receive FSM
    // ------------------------------------------------------------------
    logic        rx_meta, rx_sync;
    uart_state_e rx_state_q, rx_state_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_frame_err, rx_par_err;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= UART_RXD;
            rx_sync <= rx_meta;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // RX next state: every bit sampled at its 8th tick, bit ends after 16 ticks
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_data_d    = rx_data_q;
        rx_done      = 1'b0;
        rx_frame_err = 1'b0;
        rx_par_err   = 1'b0;
        if (tick) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
            unique case (rx_state_q)
                StIdle: begin
                    rx_cnt_d = '0;
                    if (!rx_sync) begin
                        rx_state_d = StStart;
                        rx_bit_d   = '0;
                        rx_data_d  = '0;
                    end
                end
                StStart: begin
                    // Line back high at mid start bit: treat as a glitch
                    if (rx_cnt_q == 4'd7 && rx_sync) begin
                        rx_state_d = StIdle;
                        rx_cnt_d   = '0;
                    end else if (rx_cnt_q == 4'd15) begin
                        rx_state_d = StData;
                    end
                end
                StData: begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_data_d[rx_bit_q] = rx_sync;
                    end
                    if (rx_cnt_q == 4'd15) begin
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == LAST_BIT) rx_state_d = AfterData;
                    end
                end
                StPar: begin
`ifdef UART_PARITY_EN
                    if (rx_cnt_q == 4'd7 && (rx_sync != ^rx_data_q)) begin
                        rx_par_err = 1'b1;
                    end
`endif
                    if (rx_cnt_q == 4'd15) rx_state_d = StStop;
                end
                StStop: begin
                    // Deliver at mid stop bit so the next start edge is caught on time
                    if (rx_cnt_q == 4'd7) begin
                        rx_done      = 1'b1;
                        rx_frame_err = !rx_sync;
                        rx_state_d   = StIdle;
                        rx_cnt_d     = '0;
                    end
                end
                default: begin
                    rx_state_d = StIdle;
                    rx_cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    uart_state_e tx_state_q, tx_state_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_busy;

    assign tx_busy = (tx_state_q != StIdle);

    // TX state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // TX next state: frames start on a tick so every bit is exactly 16 ticks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        if (tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            unique case (tx_state_q)
                StIdle: begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_data_d  = tx_head;
                        tx_bit_d   = '0;
                        tx_state_d = StStart;
                    end
                end
                StStart: begin
                    if (tx_cnt_q == 4'd15) tx_state_d = StData;
                end
                StData: begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        if (tx_bit_q == LAST_BIT) tx_state_d = AfterData;
                    end
                end
                StPar: begin
                    if (tx_cnt_q == 4'd15) tx_state_d = StStop;
                end
                StStop: begin
                    // Chain straight into the next start bit when more data waits
                    if (tx_cnt_q == 4'd15) begin
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_data_d  = tx_head;
                            tx_bit_d   = '0;
                            tx_state_d = StStart;
                        end else begin
                            tx_state_d = StIdle;
                        end
                    end
                end
                default: begin
                    tx_state_d = StIdle;
                    tx_cnt_d   = '0;
                end
            endcase
        end
    end

    // Serial line level decoded from the TX state
    always_comb begin
        UART_TXD = 1'b1;
        unique case (tx_state_q)
            StStart: UART_TXD = 1'b0;
            StData:  UART_TXD = tx_data_q[tx_bit_q];
            StPar:   UART_TXD = ^tx_data_q;
            default: UART_TXD = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky flags, control, status, interrupt
    // ------------------------------------------------------------------
    logic       fe_q, rov_q, tov_q, pe_q;
    logic       fe_d, rov_d, tov_d, pe_d;
    logic [1:0] ctrl_q;
    logic       irq_q;
    logic [31:0] stat;

    // Sticky next state: software clear first so a same-cycle set wins
    always_comb begin
        fe_d  = fe_q;
        rov_d = rov_q;
        tov_d = tov_q;
        pe_d  = pe_q;
        if (wr_stat) begin
            if (wdata[5]) fe_d  = 1'b0;
            if (wdata[6]) rov_d = 1'b0;
            if (wdata[7]) tov_d = 1'b0;
            if (wdata[8]) pe_d  = 1'b0;
        end
        if (rx_frame_err) fe_d  = 1'b1;
        if (rx_ovf)       rov_d = 1'b1;
        if (tx_ovf)       tov_d = 1'b1;
        if (rx_par_err)   pe_d  = 1'b1;
    end

    // Flag, control and interrupt registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            fe_q   <= 1'b0;
            rov_q  <= 1'b0;
            tov_q  <= 1'b0;
            pe_q   <= 1'b0;
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            fe_q   <= fe_d;
            rov_q  <= rov_d;
            tov_q  <= tov_d;
            pe_q   <= pe_d;
            if (wr_stat) ctrl_q <= wdata[17:16];
            irq_q  <= (ctrl_q[0] && !rx_empty) ||
                      (ctrl_q[1] && (fe_q || rov_q || tov_q || pe_q));
        end
    end

    assign irq  = irq_q;
    assign stat = {14'b0, ctrl_q, 7'b0, pe_q, tov_q, rov_q, fe_q,
                   tx_busy, tx_full, tx_empty, rx_full, !rx_empty};

    // Combinational read mux; unmapped or idle bus reads return zero
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (Add == RXD_ADDR) begin
                rdata = {24'b0, (rx_empty ? 8'h00 : rx_head)};
            end else if (Add == STAT_ADDR) begin
                rdata = stat;
            end
        end
    end

endmodule
